// File: rtl/dmem_pkg.sv
// Shared types and default addresses for the data-memory responder.
// No logic; imported by dmem_responder.
// No flow control.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    localparam logic [31:0] DEF_PASS_ADR    = 32'd84;
    localparam logic [31:0] DEF_PASS_DATA   = 32'd7;
    localparam logic [31:0] DEF_SCRATCH_ADR = 32'd80;

endpackage

// File: rtl/write_log_fifo.sv
// Generic FIFO with sticky overflow flag; DEPTH must be a power of two >= 2.
// Latency: a push is visible at pop_dat the cycle after the push edge.
// Backpressure: a push while full is dropped unless a pop fires in the same cycle.
module write_log_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty, full, pop_fire, push_fire;

    // Extra MSB on each pointer distinguishes full from empty when the indices match.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_fire  = pop_rdy && !empty;
        push_fire = push_vld && (!full || pop_fire);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
        ovf_d     = ovf_q || (push_vld && !push_fire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end

    assign pop_vld  = !empty;
    assign pop_dat  = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow = ovf_q;

endmodule

// File: rtl/dmem_responder.sv
// Data RAM for a processor under test plus a pass/fail checker watching its stores.
// Latency: read_data combinational; done/pass one edge after the deciding store.
// Backpressure: none on stores; the write log drops and flags overflow when full.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS   = 64,
    parameter int          LOG_DEPTH   = 8,
    parameter logic [31:0] PASS_ADR    = DEF_PASS_ADR,
    parameter logic [31:0] PASS_DATA   = DEF_PASS_DATA,
    parameter logic [31:0] SCRATCH_ADR = DEF_SCRATCH_ADR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_write,
    input  logic [31:0] data_adr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        done,
    output logic        pass,
    output logic [15:0] write_count,
    output logic        log_valid,
    output logic [7:0]  log_adr,
    output logic [31:0] log_data,
    input  logic        log_ready,
    output logic        log_overflow
);

    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] ram_q [RAM_WORDS];
    logic [5:0]  word_idx;
    logic        ram_we;
    logic        log_push;
    logic [39:0] log_dat;

    assign word_idx = data_adr[7:2];

    // The RAM is written in every state; only aligned, in-range stores land.
    always_comb begin
        ram_we = mem_write && (data_adr[1:0] == 2'b00) && (data_adr < RAM_BYTES);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAM_WORDS; i++) ram_q[i] <= '0;
        end else if (ram_we) begin
            ram_q[word_idx] <= write_data;
        end
    end

    assign read_data = (int'(word_idx) < RAM_WORDS) ? ram_q[word_idx] : '0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        log_push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mem_write) begin
                    log_push = 1'b1;
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    // Pass match wins if the pass and scratch addresses ever coincide.
                    if (data_adr == PASS_ADR && write_data == PASS_DATA) state_d = ST_PASS;
                    else if (data_adr == SCRATCH_ADR)                   state_d = ST_RUN;
                    else                                                 state_d = ST_FAIL;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign log_dat = {data_adr[7:0], write_data};

    write_log_fifo #(
        .WIDTH (40),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk      (clk),
        .rst_n    (reset),
        .push_vld (log_push),
        .push_dat (log_dat),
        .pop_vld  (log_valid),
        .pop_rdy  (log_ready),
        .pop_dat  ({log_adr, log_data}),
        .overflow (log_overflow)
    );

    assign done        = (state_q == ST_PASS) || (state_q == ST_FAIL);
    assign pass        = (state_q == ST_PASS);
    assign write_count = cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, corner sequences, and
// randomized episodes checked against a queue/array reference model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] data_adr = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        done, pass;
    logic [15:0] write_count;
    logic        log_valid;
    logic [7:0]  log_adr;
    logic [31:0] log_data;
    logic        log_ready = 1'b0;
    logic        log_overflow;

    dmem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mem_write    (mem_write),
        .data_adr     (data_adr),
        .write_data   (write_data),
        .read_data    (read_data),
        .done         (done),
        .pass         (pass),
        .write_count  (write_count),
        .log_valid    (log_valid),
        .log_adr      (log_adr),
        .log_data     (log_data),
        .log_ready    (log_ready),
        .log_overflow (log_overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 idle, 1 running, 2 passed, 3 failed.
    int          phase;
    logic [31:0] ram_m [64];
    logic [39:0] log_m [$];
    int          cnt_m;
    bit          ovf_m;

    typedef struct {
        bit          rst;
        bit          st;
        bit          mw;
        logic [31:0] adr;
        logic [31:0] wd;
        bit          lr;
        bit          e_done;
        bit          e_pass;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vq [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        return ram_m[a[7:2]];
    endfunction

    task automatic model_reset();
        phase = 0;
        for (int i = 0; i < 64; i++) ram_m[i] = '0;
        log_m.delete();
        cnt_m = 0;
        ovf_m = 1'b0;
    endtask

    task automatic model_edge(input bit st, input bit mw, input logic [31:0] adr,
                              input logic [31:0] wd, input bit lr);
        if (mw && adr[1:0] == 2'b00 && adr < 32'd256) ram_m[adr[7:2]] = wd;
        if (lr && log_m.size() > 0) void'(log_m.pop_front());
        if (phase == 0) begin
            if (st) phase = 1;
        end else if (phase == 1 && mw) begin
            if (cnt_m < 65535) cnt_m++;
            if (log_m.size() < 8) log_m.push_back({adr[7:0], wd});
            else ovf_m = 1'b1;
            if (adr == 32'd84 && wd == 32'd7) phase = 2;
            else if (adr != 32'd80)            phase = 3;
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".done"},  64'(done),         64'(phase >= 2));
        chk({tag, ".pass"},  64'(pass),         64'(phase == 2));
        chk({tag, ".count"}, 64'(write_count),  64'(cnt_m));
        chk({tag, ".lvld"},  64'(log_valid),    64'(log_m.size() > 0));
        chk({tag, ".ovf"},   64'(log_overflow), 64'(ovf_m));
        if (log_m.size() > 0) begin
            chk({tag, ".ladr"},  64'(log_adr),  64'(log_m[0][39:32]));
            chk({tag, ".ldata"}, 64'(log_data), 64'(log_m[0][31:0]));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit st, input bit mw, input logic [31:0] adr,
                        input logic [31:0] wd, input bit lr);
        start = st; mem_write = mw; data_adr = adr; write_data = wd; log_ready = lr;
        #1;
        chk("read", 64'(read_data), 64'(m_read(adr)));
        @(posedge clk);
        model_edge(st, mw, adr, wd, lr);
        @(negedge clk);
        check_outs("step");
    endtask

    // Asserts reset between edges so the async clear is observed before any posedge.
    task automatic do_reset();
        reset = 1'b0; start = 1'b0; mem_write = 1'b0; log_ready = 1'b0;
        model_reset();
        #1;
        check_outs("rst");
        chk("rst.read", 64'(read_data), 64'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    int n_ent;
    int r;
    logic [31:0] ra, rw;

    initial begin
        // Directed table: pass sequence, wrong address, wrong data, misaligned.
        vq.push_back('{1, 1, 0, 32'd0,  32'd0, 0, 0, 0, 16'd0});
        vq.push_back('{0, 0, 1, 32'd80, 32'd3, 0, 0, 0, 16'd1});
        vq.push_back('{0, 0, 1, 32'd84, 32'd7, 0, 1, 1, 16'd2});
        vq.push_back('{0, 0, 0, 32'd84, 32'd0, 0, 1, 1, 16'd2});
        vq.push_back('{1, 1, 0, 32'd0,  32'd0, 0, 0, 0, 16'd0});
        vq.push_back('{0, 0, 1, 32'd88, 32'd5, 1, 1, 0, 16'd1});
        vq.push_back('{0, 0, 1, 32'd84, 32'd7, 1, 1, 0, 16'd1});
        vq.push_back('{1, 1, 0, 32'd0,  32'd0, 0, 0, 0, 16'd0});
        vq.push_back('{0, 0, 1, 32'd84, 32'd6, 0, 1, 0, 16'd1});
        vq.push_back('{1, 1, 0, 32'd0,  32'd0, 0, 0, 0, 16'd0});
        vq.push_back('{0, 0, 1, 32'd82, 32'd1, 0, 1, 0, 16'd1});

        model_reset();
        do_reset();

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst) do_reset();
            step(vq[i].st, vq[i].mw, vq[i].adr, vq[i].wd, vq[i].lr);
            chk($sformatf("vec%0d.done", i),  64'(done),        64'(vq[i].e_done));
            chk($sformatf("vec%0d.pass", i),  64'(pass),        64'(vq[i].e_pass));
            chk($sformatf("vec%0d.count", i), 64'(write_count), 64'(vq[i].e_cnt));
            if (i == 3) begin
                chk("pass.log0", {24'd0, log_adr, log_data}, {24'd0, 8'd80, 32'd3});
                step(0, 0, 32'd0, 32'd0, 1);
                chk("pass.log1", {24'd0, log_adr, log_data}, {24'd0, 8'd84, 32'd7});
                step(0, 0, 32'd0, 32'd0, 1);
                chk("pass.logempty", 64'(log_valid), 64'd0);
            end
        end
        // Misaligned store must not have touched word 20.
        step(0, 0, 32'd80, 32'd0, 0);
        chk("misalign.ram", 64'(read_data), 64'd0);

        // Nine logged stores with no pop overflow an 8-deep log.
        do_reset();
        step(1, 0, 32'd0, 32'd0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 32'd80, 32'(i + 1), 0);
        chk("ovf.flag", 64'(log_overflow), 64'd1);
        n_ent = 0;
        for (int k = 0; k < 12; k++) begin
            if (log_valid) n_ent++;
            step(0, 0, 32'd0, 32'd0, 1);
        end
        chk("ovf.entries", 64'(n_ent), 64'd8);

        // Same again with a pop on the ninth store: full push+pop must not drop.
        do_reset();
        step(1, 0, 32'd0, 32'd0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 32'd80, 32'(i + 1), i == 8);
        chk("noovf.flag", 64'(log_overflow), 64'd0);
        chk("noovf.head", 64'(log_data), 64'd2);
        n_ent = 0;
        for (int k = 0; k < 12; k++) begin
            if (log_valid) n_ent++;
            step(0, 0, 32'd0, 32'd0, 1);
        end
        chk("noovf.entries", 64'(n_ent), 64'd8);

        // Idle store reaches RAM but not the checker.
        do_reset();
        step(0, 1, 32'd16, 32'hDEADBEEF, 0);
        step(0, 0, 32'd16, 32'd0, 0);
        chk("idle.read", 64'(read_data), 64'hDEADBEEF);
        chk("idle.count", 64'(write_count), 64'd0);
        chk("idle.log", 64'(log_valid), 64'd0);

        // Reset in the middle of a run clears everything without waiting for a clock.
        do_reset();
        step(1, 0, 32'd0, 32'd0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 32'd80, 32'hA0 + 32'(i), 0);
        chk("midrst.pre", 64'(write_count), 64'd3);
        data_adr = 32'd80;
        do_reset();
        chk("midrst.count", 64'(write_count), 64'd0);
        step(0, 1, 32'd80, 32'd5, 0);
        chk("midrst.rearm", 64'(write_count), 64'd0);

        // Randomized episodes.
        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            for (int j = 0; j < int'($urandom_range(0, 3)); j++)
                step(0, 1, $urandom_range(0, 255), $urandom, 0);
            step(1, 0, 32'd0, 32'd0, $urandom_range(0, 1));
            for (int j = 0; j < 25; j++) begin
                r = $urandom_range(0, 11);
                if (r < 7)       ra = 32'd80;
                else if (r < 9)  ra = 32'd84;
                else if (r < 11) ra = $urandom_range(0, 255);
                else             ra = $urandom;
                rw = (ra == 32'd84 && $urandom_range(0, 1) == 1) ? 32'd7 : $urandom;
                step($urandom_range(0, 1), $urandom_range(0, 3) != 0, ra, rw,
                     $urandom_range(0, 2) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
